// File: rtl/pb_pkg.sv
// Shared definitions for the protobuf wire-format stages.
// Contents:
//   FIELD_W / FIELD_BYTES  width of one encoded field (tag varint + value varint)
//   MAX_TAG_BYTES          longest legal tag varint
//   MAX_VARINT_BYTES       longest legal value varint
//   pb_state_e             state encoding of the field packer FSM
package pb_pkg;

    localparam int FIELD_W          = 120;
    localparam int FIELD_BYTES      = FIELD_W / 8;
    localparam int MAX_TAG_BYTES    = 5;
    localparam int MAX_VARINT_BYTES = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_FLUSH
    } pb_state_e;

endpackage

// File: rtl/pb_varint_len.sv
// Combinational length finder for one encoded field.
// The tag varint starts at byte 0. The value varint starts right after it.
// Each varint ends at the first byte whose continuation bit (bit 7) is clear.
// Ports:
//   field      in   encoded field, byte k in [8k+7:8k]
//   tag_len    out  tag varint length, 1..5 (0 when malformed)
//   val_len    out  value varint length, 1..10 (0 when malformed)
//   malformed  out  a varint has no terminator within its legal length
module pb_varint_len
    import pb_pkg::*;
(
    input  logic [FIELD_W-1:0] field,
    output logic [2:0]         tag_len,
    output logic [3:0]         val_len,
    output logic               malformed
);

    // term[k] marks a byte that terminates a varint.
    logic [FIELD_BYTES-1:0] term;

    genvar gi;
    generate
        for (gi = 0; gi < FIELD_BYTES; gi++) begin : g_term
            assign term[gi] = ~field[8*gi+7];
        end
    endgenerate

    logic       tag_found;
    logic       val_found;
    logic [3:0] pos;

    always_comb begin
        tag_len   = 3'd0;
        tag_found = 1'b0;
        for (int i = 0; i < MAX_TAG_BYTES; i++) begin
            if (!tag_found && term[i]) begin
                tag_len   = 3'(i + 1);
                tag_found = 1'b1;
            end
        end

        // Highest byte examined is 5 + 9 = 14, the last byte of the field,
        // so the value search never runs past the input.
        val_len   = 4'd0;
        val_found = 1'b0;
        pos       = 4'd0;
        for (int j = 0; j < MAX_VARINT_BYTES; j++) begin
            pos = 4'(tag_len) + 4'(j);
            if (!val_found && term[pos]) begin
                val_len   = 4'(j + 1);
                val_found = 1'b1;
            end
        end

        malformed = !tag_found || !val_found;
    end

endmodule

// File: rtl/pb_field_packer.sv
// Packs encoded protobuf fields into a little-endian byte stream of
// OUT_BYTES-wide words. Each accepted field contributes exactly its true
// wire length, so consecutive fields abut with no gaps. The last field of a
// message closes the current word (possibly an empty keep=0 word), and the
// message byte count is reported one cycle after that word is taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        field handshake
//   in_field, in_last        encoded field, end-of-message flag
//   out_valid/out_ready      word handshake
//   out_data, out_keep       word and contiguous byte mask
//   out_last                 last word of the message
//   msg_len, msg_len_valid   completed message length and its pulse
//   err_malformed            pulse: accepted field was dropped
module pb_field_packer
    import pb_pkg::*;
#(
    parameter int OUT_BYTES = 8,
    parameter int LEN_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FIELD_W-1:0]     in_field,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic [LEN_W-1:0]       msg_len,
    output logic                   msg_len_valid,
    output logic                   err_malformed
);

    localparam int FILL_W = $clog2(OUT_BYTES + 1);
    localparam int DATA_W = 8 * OUT_BYTES;

    pb_state_e          state_reg;
    logic [FIELD_W-1:0] fld_reg;        // remaining field bytes, next one in [7:0]
    logic [3:0]         rem_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic               last_reg;
    logic               word_last_reg;
    logic [DATA_W-1:0]  acc_reg;
    logic [LEN_W-1:0]   msg_cnt_reg;
    logic [LEN_W-1:0]   msg_len_reg;
    logic               msg_len_valid_reg;
    logic               err_malformed_reg;

    logic [2:0] tag_len;
    logic [3:0] val_len;
    logic       malformed;
    logic [3:0] field_len;

    pb_varint_len u_varint_len (
        .field     (in_field),
        .tag_len   (tag_len),
        .val_len   (val_len),
        .malformed (malformed)
    );

    assign field_len = 4'(tag_len) + val_len;

    logic [FILL_W-1:0] fill_next;
    logic [3:0]        rem_next;

    assign fill_next = fill_reg + FILL_W'(1);
    assign rem_next  = rem_reg - 4'd1;

    // Partial-word mask: bytes below the fill pointer are valid.
    logic [OUT_BYTES-1:0] flush_keep;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_BYTES; gi++) begin : g_keep
            assign flush_keep[gi] = (FILL_W'(gi) < fill_reg);
        end
    endgenerate

    assign in_ready      = (state_reg == ST_IDLE);
    assign out_valid     = (state_reg == ST_FULL) || (state_reg == ST_FLUSH);
    assign out_data      = acc_reg;
    assign msg_len       = msg_len_reg;
    assign msg_len_valid = msg_len_valid_reg;
    assign err_malformed = err_malformed_reg;

    always_comb begin
        out_keep = '0;
        out_last = 1'b0;
        case (state_reg)
            ST_FULL: begin
                out_keep = '1;
                out_last = word_last_reg;
            end
            ST_FLUSH: begin
                out_keep = flush_keep;
                out_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            fld_reg           <= '0;
            rem_reg           <= 4'd0;
            fill_reg          <= '0;
            last_reg          <= 1'b0;
            word_last_reg     <= 1'b0;
            acc_reg           <= '0;
            msg_cnt_reg       <= '0;
            msg_len_reg       <= '0;
            msg_len_valid_reg <= 1'b0;
            err_malformed_reg <= 1'b0;
        end else begin
            msg_len_valid_reg <= 1'b0;
            err_malformed_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (malformed) begin
                            // Field is dropped; a last flag still closes the message.
                            err_malformed_reg <= 1'b1;
                            if (in_last) begin
                                state_reg <= ST_FLUSH;
                            end
                        end else begin
                            fld_reg   <= in_field;
                            rem_reg   <= field_len;
                            last_reg  <= in_last;
                            state_reg <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    for (int b = 0; b < OUT_BYTES; b++) begin
                        if (fill_reg == FILL_W'(b)) begin
                            acc_reg[8*b +: 8] <= fld_reg[7:0];
                        end
                    end
                    fld_reg     <= fld_reg >> 8;
                    fill_reg    <= fill_next;
                    rem_reg     <= rem_next;
                    msg_cnt_reg <= msg_cnt_reg + LEN_W'(1);
                    if (fill_next == FILL_W'(OUT_BYTES)) begin
                        // A field ending exactly on a word boundary closes the
                        // message in this word, so no empty word follows.
                        state_reg     <= ST_FULL;
                        word_last_reg <= (rem_next == 4'd0) && last_reg;
                    end else if (rem_next == 4'd0) begin
                        state_reg <= last_reg ? ST_FLUSH : ST_IDLE;
                    end
                end

                ST_FULL: begin
                    if (out_ready) begin
                        fill_reg      <= '0;
                        acc_reg       <= '0;
                        word_last_reg <= 1'b0;
                        if (word_last_reg) begin
                            msg_len_reg       <= msg_cnt_reg;
                            msg_len_valid_reg <= 1'b1;
                            msg_cnt_reg       <= '0;
                        end
                        state_reg <= (word_last_reg || rem_reg == 4'd0) ? ST_IDLE : ST_SHIFT;
                    end
                end

                ST_FLUSH: begin
                    if (out_ready) begin
                        fill_reg          <= '0;
                        acc_reg           <= '0;
                        msg_len_reg       <= msg_cnt_reg;
                        msg_len_valid_reg <= 1'b1;
                        msg_cnt_reg       <= '0;
                        state_reg         <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pb_field_packer.sv
module tb_pb_field_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [119:0] in_field;
    logic         in_last;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_data;
    logic [7:0]   out_keep;
    logic         out_last;
    logic [31:0]  msg_len;
    logic         msg_len_valid;
    logic         err_malformed;

    pb_field_packer #(.OUT_BYTES(8), .LEN_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_field      (in_field),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last),
        .msg_len       (msg_len),
        .msg_len_valid (msg_len_valid),
        .err_malformed (err_malformed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] len_q[$];
    logic [7:0]  pend_q[$];
    int          model_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          err_seen = 0;
    int          err_exp = 0;
    logic        ready_hold = 1'b0;
    logic        rand_ready = 1'b0;
    word_t       mon_w;
    logic [31:0] mon_len;

    // Single driver of out_ready: fixed level or random backpressure.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    // Scoreboard: compare every accepted word and every length pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word got data=%h keep=%h last=%b required no word",
                             out_data, out_keep, out_last);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (out_data !== mon_w.data || out_keep !== mon_w.keep || out_last !== mon_w.last) begin
                        bad++;
                        $display("FAIL word got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                                 out_data, out_keep, out_last, mon_w.data, mon_w.keep, mon_w.last);
                    end else begin
                        $display("word data=%h keep=%h last=%b ok", out_data, out_keep, out_last);
                    end
                end
            end
            if (msg_len_valid) begin
                total++;
                if (len_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_msg_len got %0d required no pulse", msg_len);
                end else begin
                    mon_len = len_q.pop_front();
                    if (msg_len !== mon_len) begin
                        bad++;
                        $display("FAIL msg_len got %0d required %0d", msg_len, mon_len);
                    end else begin
                        $display("msg_len=%0d ok", msg_len);
                    end
                end
            end
            if (err_malformed) err_seen++;
        end
    end

    task automatic push_word(input logic [63:0] d, input logic [7:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Reference: length of a varint starting at byte 'start', at most maxb bytes.
    function automatic int vlen(input logic [119:0] f, input int start, input int maxb);
        for (int i = 0; i < maxb; i++) begin
            if (start + i >= 15) return 0;
            if (f[8*(start+i)+7] == 1'b0) return i + 1;
        end
        return 0;
    endfunction

    task automatic model_emit(input logic l);
        logic [63:0] d;
        logic [7:0]  k;
        d = '0;
        k = '0;
        for (int i = 0; i < pend_q.size(); i++) begin
            d[8*i +: 8] = pend_q[i];
            k[i] = 1'b1;
        end
        push_word(d, k, l);
        pend_q.delete();
    endtask

    task automatic model_field(input logic [119:0] f, input logic last);
        int   tl;
        int   vl;
        int   n;
        logic ended;
        tl = vlen(f, 0, 5);
        vl = (tl == 0) ? 0 : vlen(f, tl, 10);
        n  = (tl == 0 || vl == 0) ? 0 : tl + vl;
        if (n == 0) err_exp++;
        ended = 1'b0;
        for (int k = 0; k < n; k++) begin
            pend_q.push_back(f[8*k +: 8]);
            model_cnt++;
            if (pend_q.size() == 8) begin
                ended = last && (k == n - 1);
                model_emit(ended);
            end
        end
        if (last) begin
            if (!ended) model_emit(1'b1);
            len_q.push_back(32'(model_cnt));
            model_cnt = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_field(input logic [119:0] f, input logic last);
        int waited;
        waited   = 0;
        in_field = f;
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 300) begin
                total++;
                bad++;
                $display("FAIL in_ready_timeout got in_ready=0 required 1 within 300 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            bad++;
            $display("FAIL drain got words_left=%0d lens_left=%0d required 0", exp_q.size(), len_q.size());
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_last, msg_len_valid, err_malformed} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl got rdy/vld/last/mlv/err=%b required 10000",
                     {in_ready, out_valid, out_last, msg_len_valid, err_malformed});
        end
        total++;
        if (out_data !== 64'h0 || out_keep !== 8'h0 || msg_len !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got data=%h keep=%h len=%0d required 0", out_data, out_keep, msg_len);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        ready_hold = 1'b1;
        push_word(64'h0000000000019608, 8'h07, 1'b1);
        len_q.push_back(32'd3);
        send_field(120'h019608, 1'b1);
        wait_drain();
    endtask

    task automatic test_two_msgs();
        ready_hold = 1'b1;
        push_word(64'h0000000000000310, 8'h03, 1'b1);
        len_q.push_back(32'd2);
        push_word(64'hFFFFFFFFFFFFFE10, 8'hFF, 1'b0);
        push_word(64'h000000000001FFFF, 8'h07, 1'b1);
        len_q.push_back(32'd11);
        send_field(120'h0310, 1'b1);
        send_field(120'h01FFFFFFFFFFFFFFFFFE10, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        ready_hold = 1'b1;
        // Wire bytes 08 03 10 03 18 03 20 03, first byte in [7:0].
        push_word(64'h0320031803100308, 8'hFF, 1'b1);
        len_q.push_back(32'd8);
        send_field(120'h0308, 1'b0);
        send_field(120'h0310, 1'b0);
        send_field(120'h0318, 1'b0);
        send_field(120'h0320, 1'b1);
        wait_drain();
    endtask

    task automatic test_stall();
        int k;
        ready_hold = 1'b0;
        push_word(64'hFFFFFFFFFFFFFE10, 8'hFF, 1'b0);
        push_word(64'h000000000001FFFF, 8'h07, 1'b1);
        len_q.push_back(32'd11);
        send_field(120'h01FFFFFFFFFFFFFFFFFE10, 1'b1);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 64'hFFFFFFFFFFFFFE10 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got vld=%b data=%h rdy=%b required 1 fffffffffffffe10 0",
                         c, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_hold = 1'b1;
        wait_drain();
    endtask

    task automatic test_malformed();
        logic [119:0] ones;
        ready_hold = 1'b1;
        ones = '1;
        push_word(64'h0, 8'h00, 1'b1);
        len_q.push_back(32'd0);
        err_exp++;
        send_field(ones, 1'b1);
        @(negedge clk);
        total++;
        if (err_malformed !== 1'b1) begin
            bad++;
            $display("FAIL err_pulse got %b required 1", err_malformed);
        end
        @(negedge clk);
        total++;
        if (err_malformed !== 1'b0) begin
            bad++;
            $display("FAIL err_one_cycle got %b required 0", err_malformed);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        ready_hold = 1'b1;
        send_field(120'h01FFFFFFFFFFFFFFFFFE10, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        push_word(64'h0000000000019608, 8'h07, 1'b1);
        len_q.push_back(32'd3);
        send_field(120'h019608, 1'b1);
        wait_drain();
    endtask

    task automatic gen_field(output logic [119:0] f);
        int         tl;
        int         vl;
        logic [7:0] b;
        tl = $urandom_range(1, 5);
        vl = $urandom_range(1, 10);
        f  = '0;
        for (int i = 0; i < 15; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < tl) b[7] = (i != tl - 1);
            else if (i < tl + vl) b[7] = (i != tl + vl - 1);
            f[8*i +: 8] = b;
        end
    endtask

    task automatic test_random();
        logic [119:0] f;
        logic         last;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            gen_field(f);
            if ($urandom_range(0, 9) == 0) f = '1;
            last = (i == 39) || ($urandom_range(0, 3) == 0);
            model_field(f, last);
            send_field(f, last);
        end
        wait_drain();
        rand_ready = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_field = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_two_msgs();
        test_back_to_back();
        test_stall();
        test_malformed();
        test_reset_mid();
        test_random();
        total++;
        if (err_seen !== err_exp) begin
            bad++;
            $display("FAIL err_count got %0d required %0d", err_seen, err_exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
